// File: rtl/seg_scan_pkg.sv
// Shared helpers for the seven-segment scanner: polarity mapping, one-hot
// anode select and common widths. Helpers work on 32-bit values; callers
// size-cast the result down to their own port width.
package seg_scan_pkg;

    localparam int BRIGHT_W = 4;
    localparam int MAX_W    = 32;

    // Logical "everything off" segment pattern (before polarity is applied).
    localparam logic [MAX_W-1:0] SEG_BLANK = '0;

    // Map a logical 1=on vector onto the pin polarity.
    function automatic logic [MAX_W-1:0] apply_pol(input logic [MAX_W-1:0] value,
                                                   input logic             active_low);
        return active_low ? ~value : value;
    endfunction

    // Logical anode select for one digit.
    function automatic logic [MAX_W-1:0] onehot(input logic [4:0] idx);
        return MAX_W'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: cnt runs 0..SCAN_DIV-1 within a digit slot, idx walks the
// digits. Reports the DRIVE phase and the frame capture strobe (slot 0, cnt 0).
module seg_scan_timer #(
    parameter  int NUM_DIGITS   = 6,
    parameter  int SCAN_DIV     = 100000,
    parameter  int BLANK_CYCLES = 16,
    localparam int CNT_W        = $clog2(SCAN_DIV),
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             in_drive,
    output logic             frame_cap
);

    logic [CNT_W-1:0] cnt;

    // Slot counter with digit index advance on wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign in_drive  = (cnt >= CNT_W'(BLANK_CYCLES));
    assign frame_cap = (cnt == '0) && (idx == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver with inter-digit blanking, per-digit
// enable mask and frame-synchronous snapshot of display data.
// Optional: define SEG_SCAN_PWM_EN to add the brightness port and PWM gating.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SEG_W        = 7,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SEG_SCAN_PWM_EN
    input  logic [BRIGHT_W-1:0]         brightness,
`endif
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = NUM_DIGITS'(apply_pol('0, POL));
    localparam logic [SEG_W-1:0]      SEG_OFF = SEG_W'(apply_pol(SEG_BLANK, POL));

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV || NUM_DIGITS < 1 ||
        NUM_DIGITS > MAX_W || SEG_W > MAX_W) begin : g_bad_cfg
        $error("seg_scan_mux: illegal NUM_DIGITS/SEG_W/SCAN_DIV/BLANK_CYCLES");
    end

    logic [IDX_W-1:0]                  idx;
    logic                              in_drive;
    logic                              frame_cap;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  sh_seg;
    logic [NUM_DIGITS-1:0]             sh_en;
    logic                              show;
    logic [NUM_DIGITS-1:0]             an_nxt;
    logic [SEG_W-1:0]                  seg_nxt;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .in_drive  (in_drive),
        .frame_cap (frame_cap)
    );

`ifdef SEG_SCAN_PWM_EN
    logic [BRIGHT_W-1:0] pwm;
    logic [BRIGHT_W-1:0] sh_bright;

    // Free-running duty counter; brightness is snapshotted with the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm       <= '0;
            sh_bright <= '0;
        end else begin
            pwm <= pwm + BRIGHT_W'(1);
            if (frame_cap) sh_bright <= brightness;
        end
    end
`endif

    // Next pin values: one anode and its pattern only in DRIVE of an enabled digit.
    always_comb begin
        show = in_drive && sh_en[idx];
`ifdef SEG_SCAN_PWM_EN
        show = show && (pwm <= sh_bright);
`endif
        an_nxt  = NUM_DIGITS'(apply_pol(show ? onehot(5'(idx)) : '0, POL));
        seg_nxt = SEG_W'(apply_pol(show ? MAX_W'(sh_seg[idx]) : SEG_BLANK, POL));
    end

    // Frame snapshot and registered pin drivers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_seg      <= '0;
            sh_en       <= '0;
            an_out      <= AN_OFF;
            seg_out     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            if (frame_cap) begin
                sh_seg <= seg_in;
                sh_en  <= digit_en;
            end
            an_out      <= an_nxt;
            seg_out     <= seg_nxt;
            frame_start <= frame_cap;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (6 digits, 7 segments, 8-cycle slots, 2 blank
// cycles, active-low). The reference tracks elapsed cycles since reset and
// derives slot/digit/frame from them; display data is captured into the
// model at each 48-cycle frame boundary.
module tb_seg_scan_mux;

    localparam int ND = 6;
    localparam int SW = 7;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * SD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ND*SW-1:0] seg_in;
    logic [ND-1:0]   digit_en;
    logic [SW-1:0]   seg_out;
    logic [ND-1:0]   an_out;
    logic            frame_start;
`ifdef SEG_SCAN_PWM_EN
    logic [3:0]      brightness = 4'hF;
`endif

    int checks = 0;
    int errors = 0;
    int c = 0;
    logic [ND*SW-1:0] m_seg = '0;
    logic [ND-1:0]    m_en  = '0;

    seg_scan_mux #(
        .NUM_DIGITS   (ND),
        .SEG_W        (SW),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit_en    (digit_en),
`ifdef SEG_SCAN_PWM_EN
        .brightness  (brightness),
`endif
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // One clock: predict the pins for the state before the edge, then compare.
    task automatic tick();
        logic [ND-1:0] ea;
        logic [SW-1:0] es;
        logic          ef;
        logic          show;
        int            pos;
        int            dig;
        if (!rst_n) begin
            ea = '1; es = '1; ef = 1'b0;
        end else begin
            if (c % FRAME == 0) begin
                m_seg = seg_in;
                m_en  = digit_en;
            end
            pos  = c % SD;
            dig  = (c / SD) % ND;
            show = (pos >= BC) && m_en[dig];
            ea   = show ? ~(ND'(1) << dig) : '1;
            es   = show ? ~m_seg[dig*SW +: SW] : '1;
            ef   = (c % FRAME == 0);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            c = 0; m_seg = '0; m_en = '0;
        end else begin
            c++;
        end
        checks += 3;
        assert (an_out === ea) else begin
            errors++;
            $error("FAIL an_out t=%0d got %h want %h", c, an_out, ea);
        end
        assert (seg_out === es) else begin
            errors++;
            $error("FAIL seg_out t=%0d got %h want %h", c, seg_out, es);
        end
        assert (frame_start === ef) else begin
            errors++;
            $error("FAIL frame_start t=%0d got %b want %b", c, frame_start, ef);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the model cycle sits at a given position in the frame.
    task automatic run_to(input int frame_pos);
        for (int g = 0; g < FRAME && (c % FRAME) != frame_pos; g++) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        seg_in   = '0;
        digit_en = '0;
        run(3);

        // Scan order: digit i shows i+1, all enabled.
        for (int i = 0; i < ND; i++) seg_in[i*SW +: SW] = SW'(i + 1);
        digit_en = '1;
        rst_n    = 1'b1;
        run(FRAME + 12);

        // Alternate digits masked off.
        digit_en = 6'b101010;
        run(2 * FRAME);

        // Snapshot: change digit 5 during slot 2.
        digit_en = '1;
        run_to(2 * SD + 3);
        seg_in[5*SW +: SW] = 7'h55;
        run(2 * FRAME);

        // Random patterns and masks changed at arbitrary points.
        for (int k = 0; k < 20; k++) begin
            seg_in   = {$urandom, $urandom};
            digit_en = ND'($urandom);
            run($urandom_range(40, 1));
        end
        run(FRAME);

        // Reset in the middle of slot 3 DRIVE, then restart.
        run_to(3 * SD + 4);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        seg_in   = {$urandom, $urandom};
        digit_en = '1;
        run(FRAME + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
